exec_unit: RTL

Execute stage directly downstream of the register bank. Consumes the two read operands (dr1/dr2), performs ALU, shift and iterative multiply/divide operations, and produces the write-back triple (data, destination, enable) that drives the bank's di/dir/ena write port. Holds the HI/LO pair for multiply/divide results.

---
 rtl/exec_pkg.sv | 35 +++
 rtl/muldiv_iter.sv | 99 +++++++++
 rtl/exec_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: operation codes, default
// widths and the encoding of the multiply/divide sequencing FSM.
package exec_pkg;

  localparam int DEF_WIDTH = 32;  // operand/result width
  localparam int DEF_AW    = 5;   // register address width
  localparam int ITER      = 32;  // multiply/divide steps (equals width)

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_MFHI  = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one
// radix-2 step per cycle.
//   start_i  : load operands and clear the step counter
//   is_div_i : 1 = divide (a_i / b_i), 0 = multiply (a_i * b_i)
//   step_i   : perform one step this cycle
//   done_o   : this step is the last one; hi_o/lo_o hold the final result
//   hi_o/lo_o: accumulator value after the current step (HI:LO)
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             step_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend/quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor
  logic               is_div_q;
  logic               dbz_q;       // divide by zero: result preloaded, steps frozen
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Shifted remainder needs one extra bit; diff[WIDTH] is the borrow.
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (start_i) begin
      cnt_d = '0;
      if (is_div_i && (b_i == '0)) begin
        acc_d = {a_i, {WIDTH{1'b1}}};   // HI = dividend, LO = all ones
      end else if (is_div_i) begin
        acc_d = {{WIDTH{1'b0}}, a_i};
      end else begin
        acc_d = {{WIDTH{1'b0}}, b_i};
      end
    end else if (step_i) begin
      cnt_d  = cnt_q + 1'b1;
      done_o = (cnt_q == CW'(WIDTH - 1));
      if (!dbz_q) begin
        acc_d = is_div_q ? div_next : mul_next;
      end
    end
  end

  assign hi_o = acc_d[2*WIDTH-1:WIDTH];
  assign lo_o = acc_d[WIDTH-1:0];

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (start_i) begin
        opnd_q   <= is_div_i ? b_i : a_i;
        is_div_q <= is_div_i;
        dbz_q    <= is_div_i && (b_i == '0);
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU/shifter, iterative multiply/divide with HI/LO, and
// registered write-back toward the register bank.
//   clk, rst_n              : clock, async active-low reset
//   in_valid / in_ready     : operation handshake (ready only in IDLE)
//   op, op_a, op_b, shamt,rd: operation code, operands, shift, destination
//   wr_ena, wr_dir, wr_data : bank write port (one-cycle enable pulse)
//   busy                    : multiply/divide in progress
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  input  logic [AW-1:0]    rd,
  output logic             wr_ena,
  output logic [AW-1:0]    wr_dir,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             wr_ena_q, wr_ena_d;
  logic [AW-1:0]    wr_dir_q, wr_dir_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_ITER);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_res = op_b << shamt;
      OP_SRL:  alu_res = op_b >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wr_ena_d  = 1'b0;
    wr_dir_d  = wr_dir_q;
    wr_data_d = wr_data_q;
    md_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_muldiv(op)) begin
            md_start = 1'b1;
            state_d  = ST_ITER;
          end else if (op != OP_RSVD) begin
            // Data and address always update; only the strobe is masked for r0.
            wr_data_d = alu_res;
            wr_dir_d  = rd;
            wr_ena_d  = (rd != '0);
          end
        end
      end
      ST_ITER: begin
        if (md_done) begin
          hi_d    = md_hi;
          lo_d    = md_lo;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .is_div_i (op == OP_DIVU),
    .a_i      (op_a),
    .b_i      (op_b),
    .step_i   (state_q == ST_ITER),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      wr_ena_q  <= 1'b0;
      wr_dir_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wr_ena_q  <= wr_ena_d;
      wr_dir_q  <= wr_dir_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_dir  = wr_dir_q;
  assign wr_data = wr_data_q;

endmodule
